// File: rtl/count_seq_checker.sv
// count_seq_checker: monitors a 3-bit counter and reports lock, step errors and wraps.
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   q2_i, q1_i, q0_i    counter value under test, q2_i is the MSB
//   en_i                sample enable; when low, no state updates
//   clr_err_i           synchronous clear of err_cnt_o
//   locked_o            high while the checker is locked to the count
//   err_o               one-cycle pulse per bad step while locked
//   wrap_o              one-cycle pulse per correct last-to-first step while locked
//   err_cnt_o           saturating error count
//   exp_o               next value the checker expects
// Build option: define COUNT_SEQ_CHK_GRAY_EN to check a Gray sequence instead of binary.
module count_seq_checker #(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 2,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             q2_i,
  input  logic             q1_i,
  input  logic             q0_i,
  input  logic             en_i,
  input  logic             clr_err_i,
  output logic             locked_o,
  output logic             err_o,
  output logic             wrap_o,
  output logic [ERR_W-1:0] err_cnt_o,
  output logic [2:0]       exp_o
);
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(LOSS_CNT + 1);
  typedef enum logic {SEARCH, LOCKED} state_t;
  state_t           state_q;
  logic             valid_q;
  logic [2:0]       prev_q;
  logic [GW-1:0]    good_q;
  logic [BW-1:0]    bad_q;
  logic             err_q;
  logic             wrap_q;
  logic [ERR_W-1:0] err_cnt_q;
  logic [2:0]       exp_q;
  logic [2:0]       smp;
  logic             match;
  logic             err_ev;
  logic [GW-1:0]    good_inc;
  logic [BW-1:0]    bad_inc;
  function automatic logic [2:0] nxt(input logic [2:0] x);
`ifdef COUNT_SEQ_CHK_GRAY_EN
    // Gray successor: decode to binary, step, re-encode.
    logic [2:0] b;
    b = {x[2], x[2] ^ x[1], x[2] ^ x[1] ^ x[0]} + 3'd1;
    return b ^ {1'b0, b[2:1]};
`else
    return x + 3'd1;
`endif
  endfunction
  assign smp      = {q2_i, q1_i, q0_i};
  assign match    = smp == nxt(prev_q);
  assign err_ev   = en_i && valid_q && state_q == LOCKED && !match;
  assign good_inc = good_q + GW'(1);
  assign bad_inc  = bad_q + BW'(1);
  assign locked_o  = state_q == LOCKED;
  assign err_o     = err_q;
  assign wrap_o    = wrap_q;
  assign err_cnt_o = err_cnt_q;
  assign exp_o     = exp_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= SEARCH;
      valid_q   <= 1'b0;
      prev_q    <= '0;
      good_q    <= '0;
      bad_q     <= '0;
      err_q     <= 1'b0;
      wrap_q    <= 1'b0;
      err_cnt_q <= '0;
      exp_q     <= '0;
    end else begin
      err_q  <= err_ev;
      wrap_q <= en_i && valid_q && state_q == LOCKED && match && smp == 3'b000;
      // A clear wins over the old count but still keeps an error from this cycle.
      if (clr_err_i)
        err_cnt_q <= err_ev ? ERR_W'(1) : '0;
      else if (err_ev && err_cnt_q != '1)
        err_cnt_q <= err_cnt_q + ERR_W'(1);
      if (en_i) begin
        prev_q  <= smp;
        valid_q <= 1'b1;
        if (valid_q) begin
          exp_q <= nxt(smp);
          if (state_q == SEARCH) begin
            good_q <= match ? good_inc : '0;
            if (match && good_inc == GW'(LOCK_CNT)) begin
              state_q <= LOCKED;
              bad_q   <= '0;
            end
          end else begin
            bad_q <= match ? '0 : bad_inc;
            if (!match && bad_inc == BW'(LOSS_CNT)) begin
              state_q <= SEARCH;
              good_q  <= '0;
            end
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_count_seq_checker.sv
// tb_count_seq_checker: directed checks of count_seq_checker lock, error, wrap and reset behaviour.
module tb_count_seq_checker;
  logic       clk = 1'b0;
  logic       rst_n, rst_n_b;
  logic       en, clr, en_b, clr_b;
  logic [2:0] smp_a, smp_b;
  logic       locked_a, err_a, wrap_a, locked_b, err_b, wrap_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;
  logic [2:0] exp_a, exp_b;
  int checks = 0;
  int errors = 0;
  logic [2:0] stall_v [3] = '{3'd5, 3'd2, 3'd7};
  logic [1:0] sat_v [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
`ifdef COUNT_SEQ_CHK_GRAY_EN
  logic [2:0] seq [5] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110};
`else
  logic [2:0] seq [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
`endif
  always #5 clk = ~clk;
  count_seq_checker dut_a (
    .clk(clk), .rst_n(rst_n), .q2_i(smp_a[2]), .q1_i(smp_a[1]), .q0_i(smp_a[0]),
    .en_i(en), .clr_err_i(clr), .locked_o(locked_a), .err_o(err_a), .wrap_o(wrap_a),
    .err_cnt_o(cnt_a), .exp_o(exp_a)
  );
  count_seq_checker #(.LOCK_CNT(4), .LOSS_CNT(100), .ERR_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .q2_i(smp_b[2]), .q1_i(smp_b[1]), .q0_i(smp_b[0]),
    .en_i(en_b), .clr_err_i(clr_b), .locked_o(locked_b), .err_o(err_b), .wrap_o(wrap_b),
    .err_cnt_o(cnt_b), .exp_o(exp_b)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask
  task automatic drv(input logic [2:0] v);
    @(negedge clk);
    smp_a = v;
    @(posedge clk);
    #1;
  endtask
  task automatic drv_b(input logic [2:0] v);
    @(negedge clk);
    smp_b = v;
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n = 1'b0; rst_n_b = 1'b0; en = 1'b1; clr = 1'b0; en_b = 1'b1; clr_b = 1'b0;
    smp_a = 3'd0; smp_b = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_locked", locked_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_wrap", wrap_a, 0);
    chk("rst_cnt", cnt_a, 0);
    chk("rst_exp", exp_a, 0);
    @(negedge clk) rst_n = 1'b1;
`ifndef COUNT_SEQ_CHK_GRAY_EN
    drv(0); drv(1); drv(2); drv(3);
    chk("lock_early", locked_a, 0);
    drv(4);
    chk("lock_5th", locked_a, 1);
    chk("exp_after4", exp_a, 5);
    drv(5);
    chk("exp_after5", exp_a, 6);
    drv(6); drv(7);
    chk("wrap_at7", wrap_a, 0);
    drv(0);
    chk("wrap_7to0", wrap_a, 1);
    chk("exp_after0", exp_a, 1);
    drv(1);
    chk("wrap_single", wrap_a, 0);
    chk("clean_cnt", cnt_a, 0);
    drv(2); drv(3); drv(4);
    chk("pre_glitch_err", err_a, 0);
    drv(6);
    chk("glitch_err", err_a, 1);
    chk("glitch_cnt", cnt_a, 1);
    chk("glitch_locked", locked_a, 1);
    drv(7);
    chk("glitch_err_end", err_a, 0);
    chk("glitch_relocked", locked_a, 1);
    drv(5);
    chk("loss1_err", err_a, 1);
    chk("loss1_locked", locked_a, 1);
    drv(5);
    chk("loss2_err", err_a, 1);
    chk("loss2_locked", locked_a, 0);
    drv(5);
    chk("loss3_err", err_a, 0);
    chk("loss3_locked", locked_a, 0);
    chk("loss_cnt", cnt_a, 3);
    drv(6); drv(7); drv(0);
    chk("relock_early", locked_a, 0);
    chk("search_wrap", wrap_a, 0);
    drv(1);
    chk("relock", locked_a, 1);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drv(stall_v[i]);
      chk("stall_err", err_a, 0);
      chk("stall_wrap", wrap_a, 0);
      chk("stall_locked", locked_a, 1);
      chk("stall_exp", exp_a, 2);
      chk("stall_cnt", cnt_a, 3);
    end
    en = 1'b1;
    drv(2);
    chk("resume_err", err_a, 0);
    chk("resume_exp", exp_a, 3);
    clr = 1'b1;
    drv(5);
    clr = 1'b0;
    chk("clr_err_cnt", cnt_a, 1);
    chk("clr_err_pulse", err_a, 1);
    clr = 1'b1;
    drv(6);
    clr = 1'b0;
    chk("clr_only_cnt", cnt_a, 0);
    chk("clr_only_locked", locked_a, 1);
`else
    drv(3'b000); drv(3'b001); drv(3'b011); drv(3'b010);
    chk("g_lock_early", locked_a, 0);
    drv(3'b110);
    chk("g_lock_5th", locked_a, 1);
    chk("g_exp", exp_a, 3'b111);
    drv(3'b111); drv(3'b101); drv(3'b100);
    chk("g_wrap_early", wrap_a, 0);
    drv(3'b000);
    chk("g_wrap", wrap_a, 1);
    drv(3'b001);
    chk("g_wrap_end", wrap_a, 0);
    chk("g_no_err", err_a, 0);
    drv(3'b010);
    chk("g_bin_step_err", err_a, 1);
    chk("g_bin_step_cnt", cnt_a, 1);
`endif
    #3 rst_n = 1'b0;
    #1;
    chk("a_async_locked", locked_a, 0);
    chk("a_async_cnt", cnt_a, 0);
    chk("a_async_exp", exp_a, 0);
    @(negedge clk) rst_n_b = 1'b1;
    for (int i = 0; i < 5; i++) drv_b(seq[i]);
    chk("b_locked", locked_b, 1);
    for (int i = 0; i < 5; i++) begin
      drv_b(seq[4]);
      chk("b_sat_cnt", cnt_b, sat_v[i]);
      chk("b_sat_err", err_b, 1);
      chk("b_sat_locked", locked_b, 1);
    end
    #3 rst_n_b = 1'b0;
    #1;
    chk("b_async_locked", locked_b, 0);
    chk("b_async_err", err_b, 0);
    chk("b_async_wrap", wrap_b, 0);
    chk("b_async_cnt", cnt_b, 0);
    chk("b_async_exp", exp_b, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
